// File: rtl/xgmii_rx_stats.sv
// xgmii_rx_stats: per-channel XGMII RX frame/byte/error rate counters.
//
// Ports:
//   sys_clk, sys_rst   156.25 MHz clock, async active-high reset
//   xgmii_rxd/rxc      NCH x 64-bit RX data, NCH x 8-bit RX control
//   clear              sync pulse: zero accumulators, window, outputs
//   sec_tick           one-cycle pulse, outputs just reloaded
//   rx_pps             good frames per window, per channel
//   rx_throughput      good-frame bytes per window (FCS incl.)
//   rx_errors          bad frames per window, per channel
//   rx_total_frames    free-running 64-bit good-frame totals, present
//                      only when XGMII_STATS_TOTAL_EN is defined
module xgmii_rx_stats #(
    parameter int NCH           = 4,
    parameter int CNT_W         = 32,
    parameter int TICKS_PER_SEC = 156250000,
    parameter int MAX_LEN       = 1518
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [64*NCH-1:0]    xgmii_rxd,
    input  logic [8*NCH-1:0]     xgmii_rxc,
    input  logic                 clear,
    output logic                 sec_tick,
    output logic [CNT_W*NCH-1:0] rx_pps,
    output logic [CNT_W*NCH-1:0] rx_throughput,
    output logic [CNT_W*NCH-1:0] rx_errors
`ifdef XGMII_STATS_TOTAL_EN
    ,
    output logic [64*NCH-1:0]    rx_total_frames
`endif
);

    localparam int TW = (TICKS_PER_SEC > 1) ?
                        $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TC = TW'(TICKS_PER_SEC - 1);
    localparam int SW = ((CNT_W > 17) ? CNT_W : 17) + 1;
    localparam logic [15:0] MAXL = 16'(MAX_LEN);

    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERR   = 8'hFE;

    typedef enum logic {IDLE, FRAME} state_t;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [16:0]      b
    );
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (|s[SW-1:CNT_W]) ? '1 : s[CNT_W-1:0];
    endfunction

    // Window counter; tick_q lines up with the output reload.
    logic [TW-1:0] win_q, win_d;
    logic          tick_q, tick_d;
    logic          win_end;

    assign win_end = (win_q == TC);

    always_comb begin
        win_d  = win_q + 1'b1;
        tick_d = 1'b0;
        if (clear) begin
            win_d = '0;
        end else if (win_end) begin
            win_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            win_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            tick_q <= tick_d;
        end
    end

    assign sec_tick = tick_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t          st_q, st_d;
        logic [15:0]     len_q, len_d;
        logic            bad_q, bad_d;
        logic [1:0]      good_n, err_n;
        logic [16:0]     byte_n;
        logic [CNT_W-1:0] pps_q, pps_d, byt_q, byt_d, err_q, err_d;
        logic [CNT_W-1:0] opps_q, opps_d, obyt_q, obyt_d;
        logic [CNT_W-1:0] oerr_q, oerr_d;

        // Walk the eight lanes in order so that several frame
        // boundaries in one word resolve in wire order.
        always_comb begin
            logic        ctl;
            logic [7:0]  byt;
            logic [15:0] flen;
            st_d   = st_q;
            len_d  = len_q;
            bad_d  = bad_q;
            good_n = '0;
            err_n  = '0;
            byte_n = '0;
            ctl    = 1'b0;
            byt    = '0;
            flen   = '0;
            for (int i = 0; i < 8; i++) begin
                ctl = xgmii_rxc[8*k + i];
                byt = xgmii_rxd[64*k + 8*i +: 8];
                if (ctl && byt == C_START && (i == 0 || i == 4)) begin
                    // Start inside a frame: lost Terminate.
                    if (st_d == FRAME) err_n = err_n + 2'd1;
                    st_d  = FRAME;
                    len_d = '0;
                    bad_d = 1'b0;
                end else if (ctl && byt == C_TERM) begin
                    if (st_d == FRAME) begin
                        // Strip preamble + SFD.
                        flen = (len_d >= 16'd7) ?
                               len_d - 16'd7 : 16'd0;
                        if (!bad_d && flen >= 16'd64 &&
                            flen <= MAXL) begin
                            good_n = good_n + 2'd1;
                            byte_n = byte_n + {1'b0, flen};
                        end else begin
                            err_n = err_n + 2'd1;
                        end
                    end
                    st_d = IDLE;
                end else if (st_d == FRAME) begin
                    if (!ctl) begin
                        if (len_d != 16'hFFFF) len_d = len_d + 16'd1;
                    end else if (byt == C_ERR) begin
                        bad_d = 1'b1;
                    end
                end
            end
        end

        always_comb begin
            logic [CNT_W-1:0] p, b, e;
            p      = sat_add(pps_q, {15'd0, good_n});
            b      = sat_add(byt_q, byte_n);
            e      = sat_add(err_q, {15'd0, err_n});
            pps_d  = p;
            byt_d  = b;
            err_d  = e;
            opps_d = opps_q;
            obyt_d = obyt_q;
            oerr_d = oerr_q;
            if (clear) begin
                pps_d  = '0;
                byt_d  = '0;
                err_d  = '0;
                opps_d = '0;
                obyt_d = '0;
                oerr_d = '0;
            end else if (win_end) begin
                opps_d = p;
                obyt_d = b;
                oerr_d = e;
                pps_d  = '0;
                byt_d  = '0;
                err_d  = '0;
            end
        end

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                st_q   <= IDLE;
                len_q  <= '0;
                bad_q  <= 1'b0;
                pps_q  <= '0;
                byt_q  <= '0;
                err_q  <= '0;
                opps_q <= '0;
                obyt_q <= '0;
                oerr_q <= '0;
            end else begin
                st_q   <= st_d;
                len_q  <= len_d;
                bad_q  <= bad_d;
                pps_q  <= pps_d;
                byt_q  <= byt_d;
                err_q  <= err_d;
                opps_q <= opps_d;
                obyt_q <= obyt_d;
                oerr_q <= oerr_d;
            end
        end

        assign rx_pps[CNT_W*k +: CNT_W]        = opps_q;
        assign rx_throughput[CNT_W*k +: CNT_W] = obyt_q;
        assign rx_errors[CNT_W*k +: CNT_W]     = oerr_q;

`ifdef XGMII_STATS_TOTAL_EN
        logic [63:0] tot_q, tot_d;

        // Only reset clears the totals; they wrap.
        always_comb begin
            tot_d = tot_q + {62'd0, good_n};
        end

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) tot_q <= '0;
            else         tot_q <= tot_d;
        end

        assign rx_total_frames[64*k +: 64] = tot_q;
`endif
    end

endmodule

// File: tb/tb_xgmii_rx_stats.sv
// tb_xgmii_rx_stats: directed bench for xgmii_rx_stats.
// Builds per-channel lane streams and checks per-window rates.
module tb_xgmii_rx_stats;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int MSZ = 32768;
    localparam logic [8:0] IDL = {1'b1, 8'h07};

    logic              clk;
    logic              sys_rst;
    logic [64*NCH-1:0] rxd;
    logic [8*NCH-1:0]  rxc;
    logic              clear;
    logic              sec_tick;
    logic [CW*NCH-1:0] rx_pps;
    logic [CW*NCH-1:0] rx_throughput;
    logic [CW*NCH-1:0] rx_errors;
`ifdef XGMII_STATS_TOTAL_EN
    logic [64*NCH-1:0] rx_total_frames;
`endif

    xgmii_rx_stats #(
        .NCH(NCH), .CNT_W(CW),
        .TICKS_PER_SEC(1000), .MAX_LEN(1518)
    ) dut (
        .sys_clk(clk),
        .sys_rst(sys_rst),
        .xgmii_rxd(rxd),
        .xgmii_rxc(rxc),
        .clear(clear),
        .sec_tick(sec_tick),
        .rx_pps(rx_pps),
        .rx_throughput(rx_throughput),
        .rx_errors(rx_errors)
`ifdef XGMII_STATS_TOTAL_EN
        ,
        .rx_total_frames(rx_total_frames)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] mem [NCH][MSZ];
    int wp [NCH];
    int rp [NCH];
    int cyc;
    int nvec;
    int nerr;

    function automatic logic [31:0] pps(input int c);
        return rx_pps[CW*c +: CW];
    endfunction
    function automatic logic [31:0] tput(input int c);
        return rx_throughput[CW*c +: CW];
    endfunction
    function automatic logic [31:0] errs(input int c);
        return rx_errors[CW*c +: CW];
    endfunction

    task automatic push_lane(input int c, input logic [8:0] v);
        if (wp[c] < rp[c]) wp[c] = rp[c];
        mem[c][wp[c]] = v;
        wp[c]++;
    endtask

    task automatic align(input int c, input int lane);
        if (wp[c] < rp[c]) wp[c] = rp[c];
        while (wp[c] % 8 != lane) push_lane(c, IDL);
    endtask

    task automatic pad_to_word(input int c, input int w);
        if (wp[c] < rp[c]) wp[c] = rp[c];
        while (wp[c] < 8 * w) push_lane(c, IDL);
    endtask

    // errj >= 0 inserts an extra 0xFE control lane before data byte errj.
    task automatic push_frame(input int c, input int sl, input int len,
                              input int errj, input bit term,
                              input int ifg);
        align(c, sl);
        push_lane(c, {1'b1, 8'hFB});
        for (int j = 0; j < 6; j++) push_lane(c, {1'b0, 8'h55});
        push_lane(c, {1'b0, 8'hD5});
        for (int j = 0; j < len; j++) begin
            if (j == errj) push_lane(c, {1'b1, 8'hFE});
            push_lane(c, {1'b0, 8'(j)});
        end
        if (term) push_lane(c, {1'b1, 8'hFD});
        for (int j = 0; j < ifg; j++) push_lane(c, IDL);
    endtask

    task automatic step();
        for (int c = 0; c < NCH; c++) begin
            for (int l = 0; l < 8; l++) begin
                logic [8:0] v;
                v = (rp[c] < wp[c]) ? mem[c][rp[c]] : IDL;
                rp[c]++;
                rxc[8*c + l]      = v[8];
                rxd[64*c + 8*l +: 8] = v[7:0];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic wait_tick(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (sec_tick !== 1'b1 && n < budget);
        nvec++;
        if (sec_tick !== 1'b1) begin
            nerr++;
            $display("FAIL tick_timeout: sec_tick=%b after %0d cycles, want 1",
                     sec_tick, n);
        end
    endtask

    task automatic do_reset();
        clear   = 1'b0;
        rxc     = '1;
        rxd     = {(8*NCH){8'h07}};
        sys_rst = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            wp[c] = 0;
            rp[c] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        sys_rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        nvec++;
        if (rx_pps !== '0 || rx_throughput !== '0 || rx_errors !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: pps=%h tput=%h err=%h, want 0",
                     rx_pps, rx_throughput, rx_errors);
        end
        nvec++;
        if (sec_tick !== 1'b0) begin
            nerr++;
            $display("FAIL reset_tick: got %b want 0", sec_tick);
        end
    endtask

    task automatic test_ch0_b2b();
        do_reset();
        for (int f = 0; f < 10; f++) push_frame(0, 0, 64, -1, 1, 12);
        align(0, 0);
        wait_tick(1100);
        nvec++;
        if (cyc !== 1000) begin
            nerr++;
            $display("FAIL tick_cycle: got %0d want 1000", cyc);
        end
        nvec++;
        if (pps(0) !== 32'd10) begin
            nerr++;
            $display("FAIL b2b_pps: got %0d want 10", pps(0));
        end
        nvec++;
        if (tput(0) !== 32'd640) begin
            nerr++;
            $display("FAIL b2b_tput: got %0d want 640", tput(0));
        end
        nvec++;
        if (errs(0) !== 32'd0) begin
            nerr++;
            $display("FAIL b2b_err: got %0d want 0", errs(0));
        end
        nvec++;
        if (rx_pps[CW*NCH-1:CW] !== '0 || rx_throughput[CW*NCH-1:CW] !== '0
            || rx_errors[CW*NCH-1:CW] !== '0) begin
            nerr++;
            $display("FAIL b2b_idle_ch: pps=%h tput=%h err=%h want 0",
                     rx_pps, rx_throughput, rx_errors);
        end
        step();
        nvec++;
        if (sec_tick !== 1'b0) begin
            nerr++;
            $display("FAIL tick_width: got %b want 0", sec_tick);
        end
        nvec++;
        if (pps(0) !== 32'd10) begin
            nerr++;
            $display("FAIL b2b_hold: got %0d want 10", pps(0));
        end
    endtask

    task automatic test_reset_clears();
        sys_rst = 1'b1;
        #2;
        test_reset();
    endtask

    task automatic test_lane4_start();
        do_reset();
        push_frame(1, 4, 1518, -1, 1, 0);
        push_frame(1, 4, 100, -1, 1, 12);
        align(1, 0);
        wait_tick(1100);
        nvec++;
        if (pps(1) !== 32'd2) begin
            nerr++;
            $display("FAIL lane4_pps: got %0d want 2", pps(1));
        end
        nvec++;
        if (tput(1) !== 32'd1618) begin
            nerr++;
            $display("FAIL lane4_tput: got %0d want 1618", tput(1));
        end
        nvec++;
        if (errs(1) !== 32'd0) begin
            nerr++;
            $display("FAIL lane4_err: got %0d want 0", errs(1));
        end
    endtask

    task automatic test_bad_frames();
        do_reset();
        push_frame(2, 0, 60, -1, 1, 12);
        push_frame(2, 0, 1519, -1, 1, 12);
        push_frame(2, 0, 64, 27, 1, 12);
        push_frame(2, 0, 64, -1, 0, 0);
        push_frame(2, 0, 64, -1, 1, 12);
        align(2, 0);
        wait_tick(1100);
        nvec++;
        if (errs(2) !== 32'd4) begin
            nerr++;
            $display("FAIL bad_err: got %0d want 4", errs(2));
        end
        nvec++;
        if (pps(2) !== 32'd1) begin
            nerr++;
            $display("FAIL bad_pps: got %0d want 1", pps(2));
        end
        nvec++;
        if (tput(2) !== 32'd64) begin
            nerr++;
            $display("FAIL bad_tput: got %0d want 64", tput(2));
        end
    endtask

    task automatic test_window_edge();
        do_reset();
        pad_to_word(0, 990);
        push_frame(0, 0, 64, -1, 1, 0);
        align(0, 0);
        pad_to_word(1, 991);
        push_frame(1, 0, 64, -1, 1, 0);
        align(1, 0);
        wait_tick(1100);
        nvec++;
        if (pps(0) !== 32'd1 || tput(0) !== 32'd64) begin
            nerr++;
            $display("FAIL edge_in: pps=%0d tput=%0d want 1/64",
                     pps(0), tput(0));
        end
        nvec++;
        if (pps(1) !== 32'd0) begin
            nerr++;
            $display("FAIL edge_early: got %0d want 0", pps(1));
        end
        wait_tick(1100);
        nvec++;
        if (cyc !== 2000) begin
            nerr++;
            $display("FAIL edge_cycle: got %0d want 2000", cyc);
        end
        nvec++;
        if (pps(0) !== 32'd0) begin
            nerr++;
            $display("FAIL edge_restart: got %0d want 0", pps(0));
        end
        nvec++;
        if (pps(1) !== 32'd1 || tput(1) !== 32'd64) begin
            nerr++;
            $display("FAIL edge_next: pps=%0d tput=%0d want 1/64",
                     pps(1), tput(1));
        end
    endtask

    task automatic test_clear();
        int starts [9];
        starts = '{10, 30, 1100, 1120, 1140, 1160, 1495, 1600, 1700};
        do_reset();
        for (int f = 0; f < 9; f++) begin
            pad_to_word(0, starts[f]);
            push_frame(0, 0, 64, -1, 1, 0);
            align(0, 0);
        end
        wait_tick(1100);
        nvec++;
        if (pps(0) !== 32'd2 || tput(0) !== 32'd128) begin
            nerr++;
            $display("FAIL clr_pre: pps=%0d tput=%0d want 2/128",
                     pps(0), tput(0));
        end
        run_to(1499);
        clear = 1'b1;
        step();
        clear = 1'b0;
        nvec++;
        if (pps(0) !== 32'd0 || tput(0) !== 32'd0) begin
            nerr++;
            $display("FAIL clr_zero: pps=%0d tput=%0d want 0/0",
                     pps(0), tput(0));
        end
        wait_tick(1100);
        nvec++;
        if (cyc !== 2500) begin
            nerr++;
            $display("FAIL clr_cycle: got %0d want 2500", cyc);
        end
        nvec++;
        if (pps(0) !== 32'd3 || tput(0) !== 32'd192) begin
            nerr++;
            $display("FAIL clr_post: pps=%0d tput=%0d want 3/192",
                     pps(0), tput(0));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pad_to_word(3, 2);
        push_frame(3, 0, 64, -1, 1, 12);
        align(3, 0);
        pad_to_word(3, 30);
        for (int f = 0; f < 3; f++) push_frame(3, 0, 64, -1, 1, 12);
        align(3, 0);
        run_to(6);
        #2 sys_rst = 1'b1;
        #2 sys_rst = 1'b0;
        cyc = 0;
        wait_tick(1100);
        nvec++;
        if (cyc !== 1000) begin
            nerr++;
            $display("FAIL rst_cycle: got %0d want 1000", cyc);
        end
        nvec++;
        if (pps(3) !== 32'd3 || tput(3) !== 32'd192) begin
            nerr++;
            $display("FAIL rst_pps: pps=%0d tput=%0d want 3/192",
                     pps(3), tput(3));
        end
        nvec++;
        if (errs(3) !== 32'd0) begin
            nerr++;
            $display("FAIL rst_err: got %0d want 0", errs(3));
        end
    endtask

`ifdef XGMII_STATS_TOTAL_EN
    task automatic test_totals();
        do_reset();
        for (int w = 0; w < 3; w++) begin
            pad_to_word(0, 1000 * w + 10);
            for (int f = 0; f < 10; f++) push_frame(0, 0, 64, -1, 1, 12);
            align(0, 0);
        end
        run_to(2499);
        clear = 1'b1;
        step();
        clear = 1'b0;
        run_to(3000);
        nvec++;
        if (rx_total_frames[63:0] !== 64'd30) begin
            nerr++;
            $display("FAIL total_ch0: got %0d want 30",
                     rx_total_frames[63:0]);
        end
        nvec++;
        if (rx_total_frames[127:64] !== 64'd0) begin
            nerr++;
            $display("FAIL total_ch1: got %0d want 0",
                     rx_total_frames[127:64]);
        end
    endtask
`endif

    initial begin
        nvec    = 0;
        nerr    = 0;
        cyc     = 0;
        clear   = 1'b0;
        rxc     = '1;
        rxd     = {(8*NCH){8'h07}};
        sys_rst = 1'b0;
        #1;
        do_reset();
        test_reset();
        test_ch0_b2b();
        test_reset_clears();
        test_lane4_start();
        test_bad_frames();
        test_window_edge();
        test_clear();
        test_reset_mid();
`ifdef XGMII_STATS_TOTAL_EN
        test_totals();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/xgmii_rx_stats.md
Name: xgmii_rx_stats

Overview:
- Parametrised multi-channel XGMII receive statistics engine; generalises the fixed two/four-port measurement taps to NCH channels.
- Sits on the clk156 domain beside the network_path instances and taps each 64-bit XGMII RX bus passively.
- Per channel, counts good frames, payload bytes and bad frames over a programmable one-second window, then latches the results as per-second rates.

Parameters:
- NCH, 4, number of XGMII channels (1..8).
- CNT_W, 32, width of every per-channel counter/output.
- TICKS_PER_SEC, 156250000, sys_clk cycles per measurement window.
- MAX_LEN, 1518, largest good frame length in bytes, FCS included.

Ports:
- sys_clk  in  1  156.25 MHz XGMII clock.
- sys_rst  in  1  asynchronous, active-high reset.
- xgmii_rxd  in  64*NCH  RX data; channel k at [64k+63:64k], lane i at bits [8i+7:8i].
- xgmii_rxc  in  8*NCH  RX control; channel k at [8k+7:8k], bit i qualifies lane i.
- clear  in  1  synchronous pulse; zeroes accumulators, window counter and latched outputs.
- sec_tick  out  1  one-cycle pulse when a window closes.
- rx_pps  out  CNT_W*NCH  good frames in the last window, per channel.
- rx_throughput  out  CNT_W*NCH  good-frame bytes in the last window, FCS included, preamble excluded.
- rx_errors  out  CNT_W*NCH  bad frames in the last window.

Behaviour:
- Reset: all outputs 0; every channel FSM goes to IDLE; window counter goes to 0.
- Lane codes (control lanes only): Start 0xFB (lane 0 or 4 only), Terminate 0xFD (any lane), Error 0xFE.
- Per-channel FSM states: IDLE, FRAME.
  - IDLE -> FRAME on Start.
  - FRAME -> IDLE on Terminate.
  - Byte count = data lanes strictly after Start and before Terminate, minus 7 (preamble + SFD).
- Byte count arithmetic: 16-bit, saturating at 0xFFFF.
- Frame classification at Terminate:
  - Good: no Error lane seen, and 64 <= len <= MAX_LEN. Good frame adds 1 to pps_acc and len to byte_acc.
  - Otherwise bad: adds 1 to err_acc.
- Start while in FRAME (missing Terminate): old frame counts bad, and a new frame starts in that cycle.
- Same word holds Terminate in lane 0..3 and Start in lane 4: close the current frame, then open the new one. Both take effect in that cycle.
- Error lane while in IDLE: ignored.
- Accumulators saturate at all-ones, never wrap.
- Window counter counts 0..TICKS_PER_SEC-1. At terminal count, all of the following happen in one cycle:
  - sec_tick = 1.
  - Outputs load the accumulator values including that cycle's events.
  - Accumulators clear.
- Latency: an event completed in cycle t appears on outputs at the first window close >= t; outputs register one cycle after the close.
- clear has priority over window close and events in the same cycle. FSM state is preserved; a frame in flight is still counted at its Terminate.
- Async reset mid-frame discards the in-flight frame; counting restarts from IDLE.

Optional Feature:
- Macro: XGMII_STATS_TOTAL_EN.
- When defined:
  - Adds port rx_total_frames, out, 64*NCH: free-running good-frame totals.
  - Totals are cleared only by sys_rst, not by clear or window close, and wrap modulo 2^64.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- NCH=4, TICKS_PER_SEC=1000; 10 back-to-back 64-byte frames on ch0 (Start lane 0, IFG 12), idle elsewhere -> at first sec_tick ch0 rx_pps=10, rx_throughput=640, rx_errors=0; ch1..3 all 0.
- ch1 frame with Start in lane 4, length 1518; then a Terminate-lane-2/Start-lane-4 word closing a 100-byte frame -> rx_pps=2, rx_throughput=1618.
- ch2 frames of 60, 1519, and 64 bytes with 0xFE in lane 3 mid-frame; plus one frame with no Terminate followed by a good 64-byte frame -> rx_errors=4, rx_pps=1, rx_throughput=64.
- Frame Terminate exactly on the terminal-count cycle -> counted in the closing window; the next window starts at 0.
- clear asserted at cycle 500 with accumulators nonzero -> all outputs 0; next sec_tick at cycle 1500 reports only post-clear traffic.
- Assert sys_rst mid-frame on ch3, release, send 3 good frames -> rx_pps=3, rx_errors=0. With XGMII_STATS_TOTAL_EN, ch0 total after 3 windows of 10 frames = 30 and is unaffected by clear.
